// File: rtl/ws2812_pkg.sv
// Shared constants, FSM encoding and pixel expansion for the WS2812 strip engine.
package ws2812_pkg;
    localparam int PIX_W      = 20;
    localparam int GRB_W      = 24;
    localparam int T0H_DEF    = 40;
    localparam int T1H_DEF    = 80;
    localparam int TBIT_DEF   = 125;
    localparam int TLATCH_DEF = 28000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // {R7,G7,B6} -> GRB888 by replicating the MSBs into the missing LSBs
    function automatic logic [GRB_W-1:0] pix_to_grb(input logic [PIX_W-1:0] pix);
        logic [6:0] r;
        logic [6:0] g;
        logic [5:0] b;
        r = pix[19:13];
        g = pix[12:6];
        b = pix[5:0];
        return {g, g[6], r, r[6], b, b[5:4]};
    endfunction
endpackage

// File: rtl/ws2812_if.sv
// Strip-region RAM read port between the engine (master) and main RAM (slave).
interface ws2812_if #(
    parameter int NUM_STRIPS = 4,
    parameter int ADDR_W     = 8
);
    import ws2812_pkg::*;

    logic [ADDR_W-1:0]           strip_raddr;
    logic                        strip_re;
    logic [NUM_STRIPS*PIX_W-1:0] strip_rdata;

    modport master (output strip_raddr, output strip_re, input strip_rdata);
    modport slave  (input strip_raddr, input strip_re, output strip_rdata);
endinterface

// File: rtl/ws2812_bit_timer.sv
// Shared WS2812 bit-period timer: cycle counter within a bit plus bit index within a pixel.
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T0H  = T0H_DEF,
    parameter int T1H  = T1H_DEF,
    parameter int TBIT = TBIT_DEF
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       i_run,
    output logic       o_phase_hi0,
    output logic       o_phase_hi1,
    output logic       o_bit_start,
    output logic       o_bit_end,
    output logic [4:0] o_bit_idx
);
    localparam int CW = $clog2(TBIT);

    logic [CW-1:0] r_cnt;
    logic [4:0]    r_idx;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!i_run) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CW'(TBIT - 1)) begin
            r_cnt <= '0;
            r_idx <= (r_idx == 5'(GRB_W - 1)) ? 5'd0 : r_idx + 5'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_phase_hi0 = (r_cnt < CW'(T0H));
    assign o_phase_hi1 = (r_cnt < CW'(T1H));
    assign o_bit_start = (r_cnt == '0);
    assign o_bit_end   = (r_cnt == CW'(TBIT - 1));
    assign o_bit_idx   = r_idx;
endmodule

// File: rtl/ws2812_engine.sv
// Reads one word per pixel from the strip RAM region per FTDI frame and drives all
// strips in lock-step with WS2812 waveforms, followed by a low latch gap.
//
// state    | meaning
// ST_IDLE  | lines low, waiting for start pulse or pending frame
// ST_PRIME | read word 0 (cycle 1), load shift regs from rdata (cycle 2)
// ST_SEND  | shifting 24 bits per pixel; prefetch next word during bit 23
// ST_LATCH | lines low for TLATCH cycles
module ws2812_engine
    import ws2812_pkg::*;
#(
    parameter int NUM_STRIPS = 4,
    parameter int NUM_PIXELS = 256,
    parameter int ADDR_W     = 8,
    parameter int T0H        = T0H_DEF,
    parameter int T1H        = T1H_DEF,
    parameter int TBIT       = TBIT_DEF,
    parameter int TLATCH     = TLATCH_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  i_full_ftdi,
    ws2812_if.master              bus,
    output logic [NUM_STRIPS-1:0] o_strip_out,
    output logic                  o_busy
);
    localparam int LW = $clog2(TLATCH + 1);

    state_t                      r_state;
    logic                        r_sync1, r_sync2, r_sync3, r_start;
    logic                        r_re, r_re_d, r_prime_ld, r_have_next, r_pending, r_busy;
    logic [ADDR_W-1:0]           r_raddr;
    logic [LW-1:0]               r_latch_cnt;
    logic [GRB_W-1:0]            r_shift [NUM_STRIPS];
    logic [NUM_STRIPS*PIX_W-1:0] r_pref;
    logic [NUM_STRIPS-1:0]       r_out;

    logic       w_hi0, w_hi1, w_bit_start, w_bit_end;
    logic [4:0] w_bit_idx;

    ws2812_bit_timer #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_bit_timer (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .i_run       (r_state == ST_SEND),
        .o_phase_hi0 (w_hi0),
        .o_phase_hi1 (w_hi1),
        .o_bit_start (w_bit_start),
        .o_bit_end   (w_bit_end),
        .o_bit_idx   (w_bit_idx)
    );

    // full_ftdi comes from the clk_60 domain; start is a registered rising edge
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_sync1 <= i_full_ftdi;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_start <= r_sync2 & ~r_sync3;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_re        <= 1'b0;
            r_re_d      <= 1'b0;
            r_raddr     <= '0;
            r_prime_ld  <= 1'b0;
            r_have_next <= 1'b0;
            r_pending   <= 1'b0;
            r_busy      <= 1'b0;
            r_latch_cnt <= '0;
            r_pref      <= '0;
            for (int s = 0; s < NUM_STRIPS; s++) r_shift[s] <= '0;
        end else begin
            r_re   <= 1'b0;
            r_re_d <= r_re;
            if (r_start && r_state != ST_IDLE) r_pending <= 1'b1;
            if (r_re_d && r_state == ST_SEND) r_pref <= bus.strip_rdata;
            case (r_state)
                ST_IDLE: begin
                    if (r_start || r_pending) begin
                        r_state    <= ST_PRIME;
                        r_re       <= 1'b1;
                        r_raddr    <= '0;
                        r_busy     <= 1'b1;
                        r_prime_ld <= 1'b0;
                        r_pending  <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    if (!r_prime_ld) begin
                        r_prime_ld <= 1'b1;
                    end else begin
                        for (int s = 0; s < NUM_STRIPS; s++)
                            r_shift[s] <= pix_to_grb(bus.strip_rdata[s*PIX_W +: PIX_W]);
                        r_have_next <= 1'b0;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_bit_start && w_bit_idx == 5'(GRB_W - 1) &&
                        r_raddr < ADDR_W'(NUM_PIXELS - 1)) begin
                        r_re        <= 1'b1;
                        r_raddr     <= r_raddr + 1'b1;
                        r_have_next <= 1'b1;
                    end
                    if (w_bit_end) begin
                        if (w_bit_idx != 5'(GRB_W - 1)) begin
                            for (int s = 0; s < NUM_STRIPS; s++)
                                r_shift[s] <= {r_shift[s][GRB_W-2:0], 1'b0};
                        end else if (r_have_next) begin
                            for (int s = 0; s < NUM_STRIPS; s++)
                                r_shift[s] <= pix_to_grb(r_pref[s*PIX_W +: PIX_W]);
                            r_have_next <= 1'b0;
                        end else begin
                            r_state     <= ST_LATCH;
                            r_latch_cnt <= LW'(TLATCH - 1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_latch_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_latch_cnt <= r_latch_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            for (int s = 0; s < NUM_STRIPS; s++)
                r_out[s] <= (r_state == ST_SEND) && (r_shift[s][GRB_W-1] ? w_hi1 : w_hi0);
        end
    end

    assign bus.strip_re    = r_re;
    assign bus.strip_raddr = r_raddr;
    assign o_strip_out     = r_out;
    assign o_busy          = r_busy;
endmodule

// File: tb/tb_ws2812_engine.sv
// Self-checking bench for ws2812_engine: waveform decoder monitor plus arithmetic GRB model.
module tb_ws2812_engine;
    localparam int NS     = 4;
    localparam int NP     = 4;
    localparam int AW     = 8;
    localparam int T0H    = 40;
    localparam int T1H    = 80;
    localparam int TBIT   = 125;
    localparam int TLATCH = 1000;
    localparam int NBITS  = NP * 24;
    localparam int FRAME  = 2 + NP * 24 * TBIT + TLATCH;

    logic          sys_clk;
    logic          rst_n;
    logic          full_ftdi;
    logic [NS-1:0] strip_out;
    logic          busy;

    ws2812_if #(.NUM_STRIPS(NS), .ADDR_W(AW)) bus ();

    ws2812_engine #(
        .NUM_STRIPS(NS), .NUM_PIXELS(NP), .ADDR_W(AW),
        .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TLATCH(TLATCH)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .i_full_ftdi (full_ftdi),
        .bus         (bus),
        .o_strip_out (strip_out),
        .o_busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [NS*20-1:0] mem [NP];
    always @(posedge sys_clk) if (bus.strip_re) bus.strip_rdata <= mem[bus.strip_raddr];

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // event recorder, sampled mid-cycle
    int rise_q [NS][$];
    int width_q[NS][$];
    int re_t_q[$];
    int re_a_q[$];
    int brise_q[$];
    int bfall_q[$];
    logic [NS-1:0] m_prev = '0;
    logic          m_busy = 1'b0;
    int            m_rise_last[NS];

    always @(negedge sys_clk) begin
        m_prev <= strip_out;
        m_busy <= busy;
        if (busy && !m_busy) brise_q.push_back(cyc);
        if (!busy && m_busy) bfall_q.push_back(cyc);
        if (bus.strip_re) begin
            re_t_q.push_back(cyc);
            re_a_q.push_back(int'(bus.strip_raddr));
        end
        for (int s = 0; s < NS; s++) begin
            if (strip_out[s] && !m_prev[s]) begin
                rise_q[s].push_back(cyc);
                m_rise_last[s] <= cyc;
            end
            if (!strip_out[s] && m_prev[s]) width_q[s].push_back(cyc - m_rise_last[s]);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int b_rise[NS];
    int b_width[NS];
    int b_re, b_brise, b_bfall, t0;

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time exceeded at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic int exp_bit(input int s, input int p, input int b);
        int w, r, g, bb, grb;
        w   = int'((mem[p] >> (s * 20)) & 80'hFFFFF);
        r   = (w >> 13) & 127;
        g   = (w >> 6) & 127;
        bb  = w & 63;
        grb = ((((g << 1) | (g >> 6)) & 255) << 16) |
              ((((r << 1) | (r >> 6)) & 255) << 8) |
              (((bb << 2) | (bb >> 4)) & 255);
        return (grb >> (23 - b)) & 1;
    endfunction

    function automatic int decode_pix(input int s, input int idx);
        int v = 0;
        for (int i = 0; i < 24; i++) v = (v << 1) | ((width_q[s][idx + i] == T1H) ? 1 : 0);
        return v;
    endfunction

    task automatic snap();
        for (int s = 0; s < NS; s++) begin
            b_rise[s]  = rise_q[s].size();
            b_width[s] = width_q[s].size();
        end
        b_re    = re_t_q.size();
        b_brise = brise_q.size();
        b_bfall = bfall_q.size();
    endtask

    task automatic fill_mem_random();
        for (int p = 0; p < NP; p++)
            for (int s = 0; s < NS; s++) mem[p][s*20 +: 20] = 20'($urandom);
    endtask

    task automatic start_frame();
        full_ftdi = 1'b0;
        repeat (6) @(negedge sys_clk);
        snap();
        t0 = cyc;
        full_ftdi = 1'b1;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc - t0 < rel) @(negedge sys_clk);
    endtask

    task automatic wait_falls(input int n, input int budget);
        int k = 0;
        while (bfall_q.size() < b_bfall + n && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        n_checks++;
        if (bfall_q.size() < b_bfall + n)
            $display("FAIL frame_timeout: busy falls seen %0d, required %0d", bfall_q.size() - b_bfall, n);
        else n_pass++;
    endtask

    task automatic check_frame(input int f);
        int ri, wi, rei, e;
        n_checks++;
        if (brise_q.size() <= b_brise + f || bfall_q.size() <= b_bfall + f) begin
            $display("FAIL frame%0d_present: busy edges missing", f);
            return;
        end
        n_pass++;
        n_checks++;
        if (bfall_q[b_bfall+f] - brise_q[b_brise+f] !== FRAME)
            $display("FAIL frame%0d_busy_len: got %0d, required %0d", f, bfall_q[b_bfall+f] - brise_q[b_brise+f], FRAME);
        else n_pass++;
        for (int s = 0; s < NS; s++) begin
            n_checks++;
            if (rise_q[s].size() < b_rise[s] + (f+1)*NBITS || width_q[s].size() < b_width[s] + (f+1)*NBITS) begin
                $display("FAIL frame%0d_bitcount s%0d: rises %0d widths %0d, required %0d", f, s,
                         rise_q[s].size() - b_rise[s], width_q[s].size() - b_width[s], (f+1)*NBITS);
                return;
            end
            n_pass++;
        end
        for (int k = 0; k < NP; k++) begin
            rei = b_re + f*NP + k;
            n_checks++;
            if (re_t_q.size() <= rei) begin
                $display("FAIL frame%0d_re%0d_missing: re pulses %0d", f, k, re_t_q.size() - b_re);
                return;
            end
            n_pass++;
            n_checks++;
            if (re_a_q[rei] !== k) $display("FAIL frame%0d_raddr%0d: got %0d, required %0d", f, k, re_a_q[rei], k);
            else n_pass++;
            e = (k == 0) ? brise_q[b_brise+f] : rise_q[0][b_rise[0] + f*NBITS + k*24 - 1];
            n_checks++;
            if (re_t_q[rei] !== e) $display("FAIL frame%0d_re%0d_time: got %0d, required %0d", f, k, re_t_q[rei], e);
            else n_pass++;
        end
        for (int s = 0; s < NS; s++) begin
            for (int i = 0; i < NBITS; i++) begin
                ri = b_rise[s] + f*NBITS + i;
                wi = b_width[s] + f*NBITS + i;
                e  = exp_bit(s, i / 24, i % 24) ? T1H : T0H;
                n_checks++;
                if (width_q[s][wi] !== e)
                    $display("FAIL frame%0d_width s%0d bit%0d: got %0d, required %0d", f, s, i, width_q[s][wi], e);
                else n_pass++;
                if (s > 0) begin
                    n_checks++;
                    if (rise_q[s][ri] !== rise_q[0][b_rise[0] + f*NBITS + i])
                        $display("FAIL frame%0d_align s%0d bit%0d: got %0d, required %0d", f, s, i,
                                 rise_q[s][ri], rise_q[0][b_rise[0] + f*NBITS + i]);
                    else n_pass++;
                end else if (i > 0) begin
                    n_checks++;
                    if (rise_q[0][ri] - rise_q[0][ri-1] !== TBIT)
                        $display("FAIL frame%0d_period bit%0d: got %0d, required %0d", f, i, rise_q[0][ri] - rise_q[0][ri-1], TBIT);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset();
        int k;
        int base_r;
        int base_re;
        rst_n = 1'b0;
        full_ftdi = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (strip_out !== '0 || busy !== 1'b0 || bus.strip_re !== 1'b0 || bus.strip_raddr !== '0)
            $display("FAIL reset_state: out=%h busy=%b re=%b raddr=%0d, required 0 0 0 0",
                     strip_out, busy, bus.strip_re, bus.strip_raddr);
        else n_pass++;
        rst_n = 1'b1;
        fill_mem_random();
        mem[0][20 +: 20] = 20'hFFFFF;
        start_frame();
        wait_rel(500);
        k = 0;
        while (strip_out === '0 && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        n_checks++;
        if (strip_out === '0) $display("FAIL reset_mid_high: lines never high after cycle 500");
        else n_pass++;
        #2;
        rst_n = 1'b0;
        full_ftdi = 1'b0;
        #1;
        n_checks++;
        if (strip_out !== '0 || busy !== 1'b0)
            $display("FAIL reset_mid_async: out=%h busy=%b, required 0 0", strip_out, busy);
        else n_pass++;
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        base_r = brise_q.size();
        base_re = re_t_q.size();
        repeat (300) @(negedge sys_clk);
        n_checks++;
        if (brise_q.size() !== base_r || re_t_q.size() !== base_re || strip_out !== '0)
            $display("FAIL reset_no_restart: busy rises %0d re %0d out=%h, required 0 0 0",
                     brise_q.size() - base_r, re_t_q.size() - base_re, strip_out);
        else n_pass++;
    endtask

    task automatic test_first_frame();
        int e;
        fill_mem_random();
        mem[0][19:0] = 20'hFE000;
        start_frame();
        wait_falls(1, FRAME + 200);
        n_checks++;
        if (re_t_q.size() <= b_re) $display("FAIL first_re_latency: no re pulse");
        else if (re_t_q[b_re] - t0 !== 4)
            $display("FAIL first_re_latency: got %0d, required 4", re_t_q[b_re] - t0);
        else n_pass++;
        n_checks++;
        if (re_t_q.size() - b_re !== NP) $display("FAIL first_re_count: got %0d, required %0d", re_t_q.size() - b_re, NP);
        else n_pass++;
        if (width_q[0].size() >= b_width[0] + 24)
            for (int i = 0; i < 24; i++) begin
                e = (i >= 8 && i < 16) ? T1H : T0H;
                n_checks++;
                if (width_q[0][b_width[0] + i] !== e)
                    $display("FAIL red_pattern bit%0d: got %0d, required %0d", i, width_q[0][b_width[0] + i], e);
                else n_pass++;
            end
        check_frame(0);
    endtask

    task automatic test_pending();
        fill_mem_random();
        start_frame();
        wait_rel(1000);
        full_ftdi = 1'b0;
        wait_rel(1005);
        full_ftdi = 1'b1;
        wait_rel(2 + NBITS * TBIT + 400);
        full_ftdi = 1'b0;
        wait_rel(2 + NBITS * TBIT + 405);
        full_ftdi = 1'b1;
        wait_falls(2, 2 * FRAME + 200);
        repeat (300) @(negedge sys_clk);
        n_checks++;
        if (brise_q.size() - b_brise !== 2 || bfall_q.size() - b_bfall !== 2)
            $display("FAIL pending_frames: rises %0d falls %0d, required 2 2",
                     brise_q.size() - b_brise, bfall_q.size() - b_bfall);
        else n_pass++;
        n_checks++;
        if (brise_q.size() - b_brise < 2) $display("FAIL pending_gap: second frame missing");
        else if (brise_q[b_brise+1] - bfall_q[b_bfall] !== 1)
            $display("FAIL pending_gap: got %0d, required 1", brise_q[b_brise+1] - bfall_q[b_bfall]);
        else n_pass++;
        n_checks++;
        if (re_t_q.size() - b_re !== 2 * NP)
            $display("FAIL pending_re_count: got %0d, required %0d", re_t_q.size() - b_re, 2 * NP);
        else n_pass++;
        check_frame(0);
        check_frame(1);
    endtask

    task automatic test_independence();
        int exp_grb[NS];
        fill_mem_random();
        mem[0] = {20'h01FC0, 20'h0003F, 20'hFFFFF, 20'h00000};
        exp_grb[0] = 24'h000000;
        exp_grb[1] = 24'hFFFFFF;
        exp_grb[2] = 24'h0000FF;
        exp_grb[3] = 24'hFF0000;
        start_frame();
        wait_falls(1, FRAME + 200);
        for (int s = 0; s < NS; s++) begin
            n_checks++;
            if (width_q[s].size() < b_width[s] + 24) $display("FAIL indep s%0d: too few bits", s);
            else if (decode_pix(s, b_width[s]) !== exp_grb[s])
                $display("FAIL indep s%0d: got %06h, required %06h", s, decode_pix(s, b_width[s]), exp_grb[s]);
            else n_pass++;
        end
        check_frame(0);
    endtask

    task automatic test_held_high();
        fill_mem_random();
        start_frame();
        wait_falls(1, FRAME + 200);
        repeat (3000) begin
            @(negedge sys_clk);
            n_checks++;
            if (strip_out !== '0 || busy !== 1'b0) begin
                $display("FAIL held_idle: out=%h busy=%b at cycle %0d, required 0 0", strip_out, busy, cyc);
                break;
            end
            n_pass++;
        end
        n_checks++;
        if (brise_q.size() - b_brise !== 1 || re_t_q.size() - b_re !== NP)
            $display("FAIL held_no_restart: busy rises %0d re %0d, required 1 %0d",
                     brise_q.size() - b_brise, re_t_q.size() - b_re, NP);
        else n_pass++;
        check_frame(0);
    endtask

    initial begin
        rst_n = 1'b0;
        full_ftdi = 1'b0;
        test_reset();
        test_first_frame();
        test_pending();
        test_independence();
        test_held_high();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
